beat_detector: RTL

Parametrised successor to the accelerometer beat generator in the AudioController path. It takes a strobed signed acceleration sample and detects beats using hysteresis thresholds, an optional absolute-value mode and a sample-counted hold-off. It emits a toggling beat level plus a one-cycle beat pulse. It also measures the inter-beat period in samples so downstream tempo logic can consume it.

---
 rtl/beat_detector.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/beat_detector.sv
// Beat detector: hysteresis thresholds on a strobed acceleration sample, optional |x| mode,
// sample-counted hold-off after re-arm, and inter-beat period measurement in valid samples.
module beat_detector #(
    parameter int unsigned DATA_W    = 16,
    parameter int          HI_THRESH = 10000,
    parameter int          LO_THRESH = 8000,
    parameter int unsigned HOLDOFF   = 64,
    parameter int unsigned PERIOD_W  = 16,
    parameter bit          ABS_MODE  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [DATA_W-1:0]   accel,
    output logic                       beat_toggle,
    output logic                       beat_pulse,
    output logic [PERIOD_W-1:0]        period,
    output logic                       period_valid,
    output logic                       armed
);

    localparam int unsigned HoldW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF);
    localparam logic signed [DATA_W-1:0] HiThr = DATA_W'(HI_THRESH);
    localparam logic signed [DATA_W-1:0] LoThr = DATA_W'(LO_THRESH);
    localparam logic signed [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [PERIOD_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        StArmed,
        StHigh,
        StHoldoff
    } state_e;

    state_e                   state_q, state_d;
    logic [HoldW-1:0]         hold_q, hold_d;
    logic [PERIOD_W-1:0]      cnt_q, cnt_d;
    logic [PERIOD_W-1:0]      cnt_inc;
    logic [PERIOD_W-1:0]      period_q, period_d;
    logic                     first_q, first_d;
    logic                     toggle_q, toggle_d;
    logic                     pulse_q, pulse_d;
    logic                     pvalid_q, pvalid_d;
    logic                     armed_q, armed_d;
    logic signed [DATA_W-1:0] mag;
    logic                     beat;

    // Negating the most-negative sample would overflow, so it saturates instead.
    always_comb begin
        mag = accel;
        if (ABS_MODE && accel[DATA_W-1]) begin
            mag = (accel == MinNeg) ? MaxPos : -accel;
        end
    end

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + PERIOD_W'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        beat    = 1'b0;
        if (sample_valid) begin
            unique case (state_q)
                StArmed: begin
                    if (mag > HiThr) begin
                        beat    = 1'b1;
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    if (mag < LoThr) begin
                        if (HOLDOFF == 0) begin
                            state_d = StArmed;
                        end else begin
                            hold_d  = HoldLoad;
                            state_d = StHoldoff;
                        end
                    end
                end
                StHoldoff: begin
                    if (hold_q <= HoldW'(1)) begin
                        hold_d  = '0;
                        state_d = StArmed;
                    end else begin
                        hold_d = hold_q - HoldW'(1);
                    end
                end
                default: begin
                    hold_d  = '0;
                    state_d = StArmed;
                end
            endcase
        end
    end

    always_comb begin
        pulse_d  = beat;
        toggle_d = toggle_q ^ beat;
        pvalid_d = beat & first_q;
        period_d = (beat && first_q) ? cnt_inc : period_q;
        first_d  = first_q | beat;
        armed_d  = (state_d == StArmed);
        cnt_d    = cnt_q;
        if (sample_valid) begin
            cnt_d = beat ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StArmed;
            hold_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            first_q  <= 1'b0;
            toggle_q <= 1'b0;
            pulse_q  <= 1'b0;
            pvalid_q <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            first_q  <= first_d;
            toggle_q <= toggle_d;
            pulse_q  <= pulse_d;
            pvalid_q <= pvalid_d;
            armed_q  <= armed_d;
        end
    end

    assign beat_toggle  = toggle_q;
    assign beat_pulse   = pulse_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign armed        = armed_q;

endmodule
